// File: rtl/stream_demux_if.sv
// Stream bundle between one producer and N_OUT consumers of the demultiplexer.
// The master modport is the environment (drives the input stream, owns out_ready);
// the slave modport is the demultiplexer itself.
interface stream_demux_if #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = 2
);
  logic [DATA_W-1:0]       in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_last;
  logic                    in_valid;
  logic                    in_ready;
  logic [N_OUT*DATA_W-1:0] out_data;
  logic [N_OUT-1:0]        out_last;
  logic [N_OUT-1:0]        out_valid;
  logic [N_OUT-1:0]        out_ready;

  modport master (
    output in_data, in_sel, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_last, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_last, in_valid, out_ready,
    output in_ready, out_data, out_last, out_valid
  );
endinterface

// File: rtl/stream_demux.sv
// 1-to-N_OUT streaming demultiplexer with packet-locked routing.
// Each channel owns a one-entry output register; a route is chosen on the
// first beat of a packet and held until the beat carrying in_last. Packets
// aimed at a non-existent channel are swallowed and counted.
module stream_demux #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  stream_demux_if.slave    bus,
  output logic             err_sel,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {IDLE, LOCK, DROP} state_t;

  state_t                  state, state_nxt;
  logic [SEL_W-1:0]        lock_sel;
  logic [SEL_W-1:0]        tgt;
  logic                    tgt_ok;
  logic                    slot_free;
  logic [N_OUT-1:0]        free;
  logic                    accept, route, drop;
  logic [N_OUT*DATA_W-1:0] data_q;
  logic [N_OUT-1:0]        last_q;
  logic [N_OUT-1:0]        valid_q;

  // Counter that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // A slot can take a beat when empty or when it is being drained this cycle.
  always_comb free = ~valid_q | bus.out_ready;

  // Resolve the effective target and whether the beat can move this cycle.
  always_comb begin
    tgt       = (state == LOCK) ? lock_sel : bus.in_sel;
    tgt_ok    = (state != DROP) && (32'(tgt) < N_OUT);
    slot_free = 1'b0;
    for (int k = 0; k < N_OUT; k++)
      if (tgt == SEL_W'(k)) slot_free = free[k];
  end

  // Beats with no real destination are always accepted so they never stall.
  assign bus.in_ready = tgt_ok ? slot_free : 1'b1;
  assign accept       = bus.in_valid && bus.in_ready;
  assign route        = accept && tgt_ok;
  assign drop         = accept && !tgt_ok;

  // Packet FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Packet FSM transitions, advanced only by accepted beats.
  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        IDLE:       if (!bus.in_last) state_nxt = tgt_ok ? LOCK : DROP;
        LOCK, DROP: if (bus.in_last)  state_nxt = IDLE;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  // Capture the route of a multi-beat packet; only read while in LOCK.
  always_ff @(posedge clk) begin
    if (state == IDLE && route && !bus.in_last) lock_sel <= bus.in_sel;
  end

  // Stage p0 -> output registers: write only the targeted slot, drain the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      last_q  <= '0;
      data_q  <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (route && tgt == SEL_W'(k)) begin
          data_q[k*DATA_W +: DATA_W] <= bus.in_data;
          last_q[k]                  <= bus.in_last;
          valid_q[k]                 <= 1'b1;
        end else if (bus.out_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  // Drop reporting: pulse the cycle after a discarded beat and count it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sel  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      err_sel <= drop;
      if (drop) drop_cnt <= sat_inc(drop_cnt);
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_last  = last_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: a 4-channel instance for routing, locking, backpressure
// and reset, and a 3-channel instance with a 2-bit drop counter for the
// invalid-select path and a randomized run against a packet-level model.
module tb_stream_demux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic        err0, err1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stream_demux_if #(.DATA_W(8), .N_OUT(4), .SEL_W(2)) if0 ();
  stream_demux_if #(.DATA_W(8), .N_OUT(3), .SEL_W(2)) if1 ();

  stream_demux #(.DATA_W(8), .N_OUT(4), .SEL_W(2), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .bus(if0), .err_sel(err0), .drop_cnt(cnt0));
  stream_demux #(.DATA_W(8), .N_OUT(3), .SEL_W(2), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .bus(if1), .err_sel(err1), .drop_cnt(cnt1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [1:0] s, input logic [7:0] d,
                        input logic l, input logic [3:0] r);
    if0.in_valid = v; if0.in_sel = s; if0.in_data = d; if0.in_last = l; if0.out_ready = r;
  endtask

  task automatic drive1(input logic v, input logic [1:0] s, input logic [7:0] d,
                        input logic l, input logic [2:0] r);
    if1.in_valid = v; if1.in_sel = s; if1.in_data = d; if1.in_last = l; if1.out_ready = r;
  endtask

  typedef struct {
    logic       v;
    logic [1:0] sel;
    logic [7:0] d;
    logic       l;
    logic [3:0] rdy;
    logic       e_ir;
    logic [3:0] e_ov;
    int         e_ch;
    logic [7:0] e_d;
    logic       e_l;
  } vec_t;

  vec_t tbl[12];

  // packet-level model state for the random run on u1
  logic       occ[3];
  logic [7:0] md[3];
  logic       ml[3];
  logic       in_pkt;
  int         pdest;
  int         drops;
  logic       pend_err;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    drive0(1'b0, 2'd0, 8'h00, 1'b0, 4'hF);
    drive1(1'b0, 2'd0, 8'h00, 1'b0, 3'b111);

    // routing, locking and backpressure vectors (one row per cycle)
    tbl[0]  = '{1'b1, 2'd0, 8'hA0, 1'b1, 4'hF, 1'b1, 4'b0001, 0,  8'hA0, 1'b1};
    tbl[1]  = '{1'b1, 2'd1, 8'hA1, 1'b1, 4'hF, 1'b1, 4'b0010, 1,  8'hA1, 1'b1};
    tbl[2]  = '{1'b1, 2'd2, 8'hA2, 1'b1, 4'hF, 1'b1, 4'b0100, 2,  8'hA2, 1'b1};
    tbl[3]  = '{1'b1, 2'd3, 8'hA3, 1'b1, 4'hF, 1'b1, 4'b1000, 3,  8'hA3, 1'b1};
    tbl[4]  = '{1'b1, 2'd2, 8'h11, 1'b0, 4'hF, 1'b1, 4'b0100, 2,  8'h11, 1'b0};
    tbl[5]  = '{1'b1, 2'd0, 8'h22, 1'b0, 4'hF, 1'b1, 4'b0100, 2,  8'h22, 1'b0};
    tbl[6]  = '{1'b1, 2'd1, 8'h33, 1'b1, 4'hF, 1'b1, 4'b0100, 2,  8'h33, 1'b1};
    tbl[7]  = '{1'b1, 2'd0, 8'h44, 1'b1, 4'hF, 1'b1, 4'b0001, 0,  8'h44, 1'b1};
    tbl[8]  = '{1'b1, 2'd1, 8'h55, 1'b1, 4'hD, 1'b1, 4'b0010, 1,  8'h55, 1'b1};
    tbl[9]  = '{1'b1, 2'd1, 8'h66, 1'b1, 4'hD, 1'b0, 4'b0010, 1,  8'h55, 1'b1};
    tbl[10] = '{1'b1, 2'd1, 8'h66, 1'b1, 4'hF, 1'b1, 4'b0010, 1,  8'h66, 1'b1};
    tbl[11] = '{1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 1'b1, 4'b0000, -1, 8'h00, 1'b0};

    // reset state, then three idle cycles
    #2;
    chk("rst_ovalid_async", 32'(if0.out_valid), 32'h0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) tick();
    chk("rst_ovalid0", 32'(if0.out_valid), 32'h0);
    chk("rst_ovalid1", 32'(if1.out_valid), 32'h0);
    chk("rst_iready0", 32'(if0.in_ready), 32'h1);
    chk("rst_cnt0",    32'(cnt0), 32'h0);
    chk("rst_err0",    32'(err0), 32'h0);
    chk("rst_cnt1",    32'(cnt1), 32'h0);

    for (int i = 0; i < 12; i++) begin
      drive0(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].l, tbl[i].rdy);
      #1;
      chk($sformatf("vec%0d_iready", i), 32'(if0.in_ready), 32'(tbl[i].e_ir));
      tick();
      chk($sformatf("vec%0d_ovalid", i), 32'(if0.out_valid), 32'(tbl[i].e_ov));
      if (tbl[i].e_ch >= 0) begin
        chk($sformatf("vec%0d_data", i), 32'(if0.out_data[tbl[i].e_ch*8 +: 8]), 32'(tbl[i].e_d));
        chk($sformatf("vec%0d_last", i), 32'(if0.out_last[tbl[i].e_ch]), 32'(tbl[i].e_l));
      end
      chk($sformatf("vec%0d_err", i), 32'(err0), 32'h0);
    end
    drive0(1'b0, 2'd0, 8'h00, 1'b0, 4'hF);
    tick();

    // dropped 3-beat packet; later beats carry valid selects that must be ignored
    for (int i = 0; i < 3; i++) begin
      drive1(1'b1, (i == 0) ? 2'd3 : 2'(i - 1), 8'(8'hC0 + i), (i == 2), 3'b111);
      #1;
      chk($sformatf("drop%0d_iready", i), 32'(if1.in_ready), 32'h1);
      tick();
      chk($sformatf("drop%0d_ovalid", i), 32'(if1.out_valid), 32'h0);
      chk($sformatf("drop%0d_err", i), 32'(err1), 32'h1);
      chk($sformatf("drop%0d_cnt", i), 32'(cnt1), 32'(i + 1));
    end
    drive1(1'b0, 2'd0, 8'h00, 1'b0, 3'b111);
    tick();
    chk("drop_err_clear", 32'(err1), 32'h0);
    chk("drop_cnt_hold", 32'(cnt1), 32'h3);

    // 5-beat dropped packet: counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      drive1(1'b1, 2'd3, 8'(i), (i == 4), 3'b111);
      tick();
      chk($sformatf("sat%0d_cnt", i), 32'(cnt1), 32'h3);
      chk($sformatf("sat%0d_err", i), 32'(err1), 32'h1);
    end
    drive1(1'b1, 2'd0, 8'h5A, 1'b1, 3'b111);
    tick();
    chk("post_drop_ovalid", 32'(if1.out_valid), 32'h1);
    chk("post_drop_data", 32'(if1.out_data[7:0]), 32'h5A);
    chk("post_drop_err", 32'(err1), 32'h0);
    drive1(1'b0, 2'd0, 8'h00, 1'b0, 3'b111);

    // reset mid-packet with a stalled beat on channel 2
    drive0(1'b1, 2'd2, 8'h77, 1'b0, 4'b1011);
    tick();
    chk("lock_ovalid", 32'(if0.out_valid), 32'h4);
    drive0(1'b0, 2'd0, 8'h00, 1'b0, 4'b1011);
    #1 rst = 1'b1;
    #1;
    chk("midrst_ovalid", 32'(if0.out_valid), 32'h0);
    #1 rst = 1'b0;
    tick();
    drive0(1'b1, 2'd0, 8'h88, 1'b1, 4'hF);
    #1;
    chk("after_rst_iready", 32'(if0.in_ready), 32'h1);
    tick();
    chk("after_rst_ovalid", 32'(if0.out_valid), 32'h1);
    chk("after_rst_data", 32'(if0.out_data[7:0]), 32'h88);
    drive0(1'b0, 2'd0, 8'h00, 1'b0, 4'hF);

    // randomized traffic on the 3-channel instance against the packet model
    for (int k = 0; k < 3; k++) begin occ[k] = 1'b0; md[k] = '0; ml[k] = 1'b0; end
    in_pkt = 1'b0; pdest = 0; drops = 0; pend_err = 1'b0;
    for (int n = 0; n < 500; n++) begin
      logic       v, l, exp_ir, acc;
      logic [1:0] s;
      logic [7:0] d;
      logic [2:0] r;
      int         dest;
      for (int k = 0; k < 3; k++) begin
        chk("rnd_ovalid", 32'(if1.out_valid[k]), 32'(occ[k]));
        if (occ[k]) begin
          chk("rnd_data", 32'(if1.out_data[k*8 +: 8]), 32'(md[k]));
          chk("rnd_last", 32'(if1.out_last[k]), 32'(ml[k]));
        end
      end
      chk("rnd_err", 32'(err1), 32'(pend_err));
      chk("rnd_cnt", 32'(cnt1), (drops > 3) ? 32'd3 : 32'(drops));

      v = ($urandom_range(0, 3) != 0);
      s = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      l = ($urandom_range(0, 2) == 0);
      r = 3'($urandom_range(0, 7));
      drive1(v, s, d, l, r);
      #1;
      dest   = in_pkt ? pdest : int'(s);
      exp_ir = (dest >= 3) ? 1'b1 : (!occ[dest] || r[dest]);
      chk("rnd_iready", 32'(if1.in_ready), 32'(exp_ir));
      acc = v && exp_ir;
      for (int k = 0; k < 3; k++) if (occ[k] && r[k]) occ[k] = 1'b0;
      pend_err = 1'b0;
      if (acc) begin
        if (dest >= 3) begin
          drops++;
          pend_err = 1'b1;
        end else begin
          occ[dest] = 1'b1; md[dest] = d; ml[dest] = l;
        end
        in_pkt = !l;
        pdest  = dest;
      end
      tick();
    end
    drive1(1'b0, 2'd0, 8'h00, 1'b0, 3'b111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
